debounce_scheduler: RTL and testbench

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

---
 rtl/debounce_pkg.sv | 12 +
 rtl/sync_2ff.sv | 24 ++
 rtl/debounce_scheduler.sv | 94 +++++++++
 tb/tb_debounce_scheduler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helpers for the time-multiplexed switch debouncer.
package debounce_pkg;

   localparam int DEF_N_CHANNELS     = 4;
   localparam int DEF_DEBOUNCE_LIMIT = 20;

   // Width of a per-channel count; it only ever holds 0..limit-1.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous switch levels.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/debounce_scheduler.sv
// Round-robin debouncer: one channel per cycle is compared against its accepted
// level by a single shared count/update datapath.
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter int N_CHANNELS     = DEF_N_CHANNELS,
   parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_scan_en,
   input  logic [N_CHANNELS-1:0]         i_bouncy,
   output logic [N_CHANNELS-1:0]         o_debounced,
   output logic [N_CHANNELS-1:0]         o_rise,
   output logic [N_CHANNELS-1:0]         o_fall,
   output logic [$clog2(N_CHANNELS)-1:0] o_slot
);

   localparam int              CW        = cnt_width(DEBOUNCE_LIMIT);
   localparam int              SW        = $clog2(N_CHANNELS);
   localparam logic [CW-1:0]   CNT_MAX   = CW'(DEBOUNCE_LIMIT - 1);
   localparam logic [SW-1:0]   SLOT_LAST = SW'(N_CHANNELS - 1);

   logic [N_CHANNELS-1:0] sync;

   for (genvar k = 0; k < N_CHANNELS; k++) begin : g_sync
      sync_2ff u_sync (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .i_d   (i_bouncy[k]),
         .o_q   (sync[k])
      );
   end

   logic [SW-1:0]         slot_q, slot_d;
   logic [CW-1:0]         cnt_q [N_CHANNELS];
   logic [N_CHANNELS-1:0] deb_q, deb_d;
   logic [N_CHANNELS-1:0] rise_q, rise_d;
   logic [N_CHANNELS-1:0] fall_q, fall_d;

   logic          s_sel;
   logic          deb_sel;
   logic [CW-1:0] cnt_sel;
   logic [CW-1:0] cnt_d;
   logic          mismatch;
   logic          accept;

   // Shared datapath: select the visited channel, decide its next count/level.
   always_comb begin
      s_sel    = sync[slot_q];
      deb_sel  = deb_q[slot_q];
      cnt_sel  = cnt_q[slot_q];
      mismatch = s_sel ^ deb_sel;
      accept   = mismatch && (cnt_sel >= CNT_MAX);
      cnt_d    = (!mismatch || accept) ? '0 : cnt_sel + CW'(1);
   end

   always_comb begin
      deb_d  = deb_q;
      rise_d = '0;
      fall_d = '0;
      slot_d = slot_q;
      if (i_scan_en) begin
         slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
         if (accept) begin
            deb_d[slot_q]  = s_sel;
            rise_d[slot_q] = s_sel;
            fall_d[slot_q] = ~s_sel;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         slot_q <= '0;
         deb_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         for (int k = 0; k < N_CHANNELS; k++) cnt_q[k] <= '0;
      end else begin
         slot_q <= slot_d;
         deb_q  <= deb_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         if (i_scan_en) cnt_q[slot_q] <= cnt_d;
      end
   end

   assign o_debounced = deb_q;
   assign o_rise      = rise_q;
   assign o_fall      = fall_q;
   assign o_slot      = slot_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed + random bench for debounce_scheduler against a per-channel reference model.
module tb_debounce_scheduler;

   localparam int N   = 4;
   localparam int LIM = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en  = 1'b1;
   logic [N-1:0] bouncy = '0;
   logic [N-1:0] deb, rise, fall;
   logic [1:0]   slot;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [N-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_rise = '0, m_fall = '0;
   int           m_slot = 0;
   int           m_cnt [N] = '{default: 0};

   debounce_scheduler #(.N_CHANNELS(N), .DEBOUNCE_LIMIT(LIM)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_scan_en   (en),
      .i_bouncy    (bouncy),
      .o_debounced (deb),
      .o_rise      (rise),
      .o_fall      (fall),
      .o_slot      (slot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock edge of the behaviour: the visited channel sees the 2-cycle-old input.
   task automatic model_edge();
      int k;
      m_rise = '0;
      m_fall = '0;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_deb = '0; m_slot = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
         if (en) begin
            k = m_slot;
            if (m_s2[k] == m_deb[k]) m_cnt[k] = 0;
            else if (m_cnt[k] < LIM - 1) m_cnt[k]++;
            else begin
               m_deb[k] = m_s2[k];
               m_cnt[k] = 0;
               if (m_s2[k]) m_rise[k] = 1'b1; else m_fall[k] = 1'b1;
            end
            m_slot = (m_slot + 1) % N;
         end
         m_s2 = m_s1;
         m_s1 = bouncy;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("debounced", deb, m_deb);
      chk("rise", rise, m_rise);
      chk("fall", fall, m_fall);
      chk("slot", slot, m_slot);
      for (int i = 0; i < N; i++) chk($sformatf("cnt%0d", i), dut.cnt_q[i], m_cnt[i]);
      chk("pulse_onehot", ($countones(rise | fall) <= 1), 1);
   endtask

   initial begin
      int lat, n_rise, n_pulse, visits, waited, saved_slot;
      int rc [N];

      // reset with all inputs high
      rst = 1'b1; bouncy = 4'hF;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_deb", deb, 0);
         chk("rst_pulse", rise | fall, 0);
         chk("rst_slot", slot, 0);
      end
      bouncy = '0; rst = 1'b0;
      chk("release_slot", slot, 0);
      for (int c = 0; c < 6; c++) step();

      // clean press on channel 0
      bouncy = 4'b0001; lat = -1; n_rise = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (rise[0]) n_rise++;
         if (lat < 0 && deb[0]) lat = c;
      end
      chk("press_latency", (lat > 0 && lat <= 2 + LIM * N), 1);
      chk("press_rise_once", n_rise, 1);
      chk("press_others", deb[3:1], 0);

      // 6-cycle glitch on channel 1
      bouncy = 4'b0011; n_pulse = 0;
      for (int c = 0; c < 6; c++) begin step(); n_pulse += int'(rise[1] | fall[1]); end
      bouncy = 4'b0001;
      for (int c = 0; c < 12; c++) begin step(); n_pulse += int'(rise[1] | fall[1]); end
      chk("glitch_deb", deb[1], 0);
      chk("glitch_pulses", n_pulse, 0);
      chk("glitch_cnt", dut.cnt_q[1], 0);

      // all low, then simultaneous 0->F aligned so slot 0 is the first to see it
      bouncy = '0;
      for (int c = 0; c < 20; c++) step();
      chk("all_low", deb, 0);
      waited = 0;
      while (slot != 2 && waited < 8) begin step(); waited++; end
      chk("align_slot", slot, 2);
      bouncy = 4'hF;
      for (int i = 0; i < N; i++) rc[i] = -1;
      for (int c = 0; c < 30; c++) begin
         step();
         for (int i = 0; i < N; i++) if (rise[i]) rc[i] = c;
      end
      chk("simul_all_high", deb, 4'hF);
      chk("simul_first", (rc[0] >= 0), 1);
      for (int i = 1; i < N; i++) chk($sformatf("simul_order%0d", i), rc[i], rc[0] + i);

      // reset after two mismatching visits of channel 2
      bouncy = '0;
      for (int c = 0; c < 20; c++) step();
      bouncy = 4'b0100; waited = 0;
      while (m_cnt[2] != 2 && waited < 20) begin step(); waited++; end
      chk("midcnt_reached", m_cnt[2], 2);
      rst = 1'b1;
      step(); step();
      chk("midcnt_rst_cnt", dut.cnt_q[2], 0);
      chk("midcnt_rst_deb", deb, 0);
      chk("midcnt_rst_pulse", rise | fall, 0);
      rst = 1'b0; visits = 0;
      for (int c = 0; c < 20; c++) begin
         if (slot == 2) visits++;
         step();
         if (deb[2]) break;
      end
      chk("midcnt_deb", deb[2], 1);
      chk("midcnt_visits", visits, 3);

      // freeze mid-count on channel 3
      bouncy = 4'b1100; waited = 0;
      while (m_cnt[3] != 1 && waited < 20) begin step(); waited++; end
      chk("freeze_reached", m_cnt[3], 1);
      en = 1'b0; saved_slot = slot;
      for (int c = 0; c < 20; c++) begin
         step();
         chk("freeze_slot", slot, saved_slot);
         chk("freeze_cnt", dut.cnt_q[3], 1);
         chk("freeze_pulse", rise | fall, 0);
      end
      en = 1'b1; visits = 0;
      for (int c = 0; c < 20; c++) begin
         if (slot == 3) visits++;
         step();
         if (deb[3]) break;
      end
      chk("freeze_deb", deb[3], 1);
      chk("freeze_visits", visits, 2);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(5) == 0) bouncy[$urandom_range(N - 1)] ^= 1'b1;
         en  = ($urandom_range(7) != 0);
         rst = ($urandom_range(99) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
